// File: rtl/sba_pkg.sv
// Shared definitions for the system bus access engine: register selects,
// error codes, FSM states and SBCS field positions.
package sba_pkg;

    localparam logic [1:0] SbcsSel   = 2'd0;
    localparam logic [1:0] SbAddrSel = 2'd1;
    localparam logic [1:0] SbDataSel = 2'd2;

    localparam logic [2:0] SbAccess32 = 3'd2;

    typedef enum logic [2:0] {
        ErrNone    = 3'd0,
        ErrTimeout = 3'd1,
        ErrBadAddr = 3'd2,
        ErrAlign   = 3'd3,
        ErrSize    = 3'd4
    } sberror_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } sba_state_e;

    localparam int unsigned SbcsVersionLsb    = 29;
    localparam int unsigned SbcsBusyErrBit    = 22;
    localparam int unsigned SbcsBusyBit       = 21;
    localparam int unsigned SbcsReadOnAddrBit = 20;
    localparam int unsigned SbcsAccessLsb     = 17;
    localparam int unsigned SbcsAutoIncBit    = 16;
    localparam int unsigned SbcsReadOnDataBit = 15;
    localparam int unsigned SbcsErrorLsb      = 12;
    localparam int unsigned SbcsAsizeLsb      = 5;
    localparam int unsigned SbcsAccess32Bit   = 2;

endpackage

// File: rtl/sba_initiator_if.sv
// System bus side of the SBA engine: single 32-bit read/write requests held
// as levels until the responder acks or errors.
interface sba_initiator_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_addr, bus_wdata, bus_rd, bus_wr,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_rd, bus_wr,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/sba_initiator.sv
// RISC-V debug System Bus Access engine: turns SBCS/SBADDRESS0/SBDATA0 writes into
// single bus transactions. Define SBA_TIMEOUT_EN to enable the response timeout.
module sba_initiator
    import sba_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  reg_sel,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    sba_initiator_if.master bus
);

    if ((TimeoutCycles < 1) || (TimeoutCycles > 65535)) begin : g_bad_timeout
        $error("sba_initiator: TimeoutCycles must be in 1..65535");
    end

    sba_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  access_q, access_d;
    logic [2:0]  sberror_q, sberror_d;
    logic        busy_err_q, busy_err_d;
    logic        read_on_addr_q, read_on_addr_d;
    logic        auto_inc_q, auto_inc_d;
    logic        read_on_data_q, read_on_data_d;

    logic        busy, blocked, timeout;
    logic        start_rd, start_wr;
    logic [31:0] start_addr;
    logic [31:0] sbcs;

    assign busy    = (state_q != StIdle);
    assign blocked = (sberror_q != 3'd0) || busy_err_q;

`ifdef SBA_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero while idle so every access starts counting from zero.
    always_comb begin
        tmo_cnt_d = busy ? tmo_cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tmo_cnt_q <= 16'd0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end

    assign timeout = busy && (tmo_cnt_q == 16'(TimeoutCycles - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        access_d       = access_q;
        sberror_d      = sberror_q;
        busy_err_d     = busy_err_q;
        read_on_addr_d = read_on_addr_q;
        auto_inc_d     = auto_inc_q;
        read_on_data_d = read_on_data_q;
        start_rd       = 1'b0;
        start_wr       = 1'b0;
        start_addr     = addr_q;

        if (reg_wr) begin
            case (reg_sel)
                SbcsSel: begin
                    read_on_addr_d = reg_wdata[SbcsReadOnAddrBit];
                    access_d       = reg_wdata[SbcsAccessLsb +: 3];
                    auto_inc_d     = reg_wdata[SbcsAutoIncBit];
                    read_on_data_d = reg_wdata[SbcsReadOnDataBit];
                    if (reg_wdata[SbcsBusyErrBit]) busy_err_d = 1'b0;
                    sberror_d = sberror_q & ~reg_wdata[SbcsErrorLsb +: 3];
                end
                SbAddrSel: begin
                    if (busy) begin
                        busy_err_d = 1'b1;
                    end else begin
                        addr_d     = reg_wdata;
                        start_addr = reg_wdata;
                        start_rd   = read_on_addr_q && !blocked;
                    end
                end
                SbDataSel: begin
                    if (busy) begin
                        busy_err_d = 1'b1;
                    end else begin
                        data_d   = reg_wdata;
                        start_wr = !blocked;
                    end
                end
                default: ;
            endcase
        end else if (reg_rd && (reg_sel == SbDataSel)) begin
            if (busy) busy_err_d = 1'b1;
            else      start_rd   = read_on_data_q && !blocked;
        end

        // Pre-checks fail without ever raising a bus strobe.
        if (start_rd || start_wr) begin
            if (access_q != SbAccess32) begin
                sberror_d = ErrSize;
            end else if (start_addr[1:0] != 2'b00) begin
                sberror_d = ErrAlign;
            end else begin
                bus_addr_d = start_addr;
                if (start_wr) begin
                    bus_wdata_d = reg_wdata;
                    state_d     = StWrite;
                end else begin
                    state_d = StRead;
                end
            end
        end

        if (busy) begin
            if (bus.bus_err) begin
                sberror_d = ErrBadAddr;
                state_d   = StIdle;
            end else if (bus.bus_ack) begin
                if (state_q == StRead) data_d = bus.bus_rdata;
                if (auto_inc_q)        addr_d = addr_q + 32'd4;
                state_d = StIdle;
            end else if (timeout) begin
                sberror_d = ErrTimeout;
                state_d   = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            addr_q         <= 32'd0;
            data_q         <= 32'd0;
            bus_addr_q     <= 32'd0;
            bus_wdata_q    <= 32'd0;
            access_q       <= SbAccess32;
            sberror_q      <= 3'd0;
            busy_err_q     <= 1'b0;
            read_on_addr_q <= 1'b0;
            auto_inc_q     <= 1'b0;
            read_on_data_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            access_q       <= access_d;
            sberror_q      <= sberror_d;
            busy_err_q     <= busy_err_d;
            read_on_addr_q <= read_on_addr_d;
            auto_inc_q     <= auto_inc_d;
            read_on_data_q <= read_on_data_d;
        end
    end

    always_comb begin
        sbcs                              = 32'd0;
        sbcs[SbcsVersionLsb +: 3]         = 3'd1;
        sbcs[SbcsBusyErrBit]              = busy_err_q;
        sbcs[SbcsBusyBit]                 = busy;
        sbcs[SbcsReadOnAddrBit]           = read_on_addr_q;
        sbcs[SbcsAccessLsb +: 3]          = access_q;
        sbcs[SbcsAutoIncBit]              = auto_inc_q;
        sbcs[SbcsReadOnDataBit]           = read_on_data_q;
        sbcs[SbcsErrorLsb +: 3]           = sberror_q;
        sbcs[SbcsAsizeLsb +: 7]           = 7'd32;
        sbcs[SbcsAccess32Bit]             = 1'b1;
    end

    always_comb begin
        case (reg_sel)
            SbcsSel:   reg_rdata = sbcs;
            SbAddrSel: reg_rdata = addr_q;
            SbDataSel: reg_rdata = data_q;
            default:   reg_rdata = 32'd0;
        endcase
    end

    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_rd    = (state_q == StRead);
    assign bus.bus_wr    = (state_q == StWrite);

endmodule

// File: doc/sba_initiator.md
# sba_initiator

RISC-V debug System Bus Access (SBA) engine: the bus-initiator counterpart to the memory-mapped peripherals (GPIO, etc.) that respond on the arilla bus. The debug module writes SBCS/SBADDRESS0/SBDATA0 through a simple register port. The block converts those writes into single 32-bit read/write transactions on the system bus, then reports data and errors back. It sits between the debug module register file and the arilla bus arbiter's debug initiator port.

## Interface
- TimeoutCycles, 255: cycles to wait for bus_ack/bus_err before flagging timeout; valid range 1..65535.
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- reg_sel  in  2  0=SBCS, 1=SBADDRESS0, 2=SBDATA0, 3=reserved (reads 0, writes ignored)
- reg_wr  in  1  write strobe, one cycle
- reg_rd  in  1  read strobe, one cycle; reg_wr and reg_rd never assert together
- reg_wdata  in  32  write data
- reg_rdata  out  32  combinational read data for reg_sel
- bus_addr  out  32  transaction address, registered
- bus_wdata  out  32  write data, registered
- bus_rd  out  1  read request, level, held until completion
- bus_wr  out  1  write request, level, held until completion
- bus_rdata  in  32  read data, valid in the bus_ack cycle
- bus_ack  in  1  responder completion
- bus_err  in  1  responder error completion; has priority over bus_ack

## Operation
- SBCS fields: [31:29] sbversion=1 (RO); [22] sbbusyerror (W1C); [21] sbbusy (RO); [20] sbreadonaddr; [19:17] sbaccess, reset 2; [16] sbautoincrement; [15] sbreadondata; [14:12] sberror (W1C, per bit); [11:5] sbasize=32 (RO); [2] sbaccess32=1 (RO); all others 0.
- FSM states: IDLE, READ, WRITE. Only IDLE accepts new accesses.
- Start conditions: write SBADDRESS0 with sbreadonaddr=1 starts a READ; write SBDATA0 starts a WRITE of the written value; read SBDATA0 with sbreadondata=1 returns the current value, then starts a READ.
- Blocked starts: no access starts while sberror≠0 or sbbusyerror=1. The register write still lands.
- Busy access: any SBADDRESS0 write, SBDATA0 write or SBDATA0 read while sbbusy=1 sets sbbusyerror. The write is dropped.
- Pre-checks at start, with no bus cycle issued:
  - sbaccess≠2 → sberror=4.
  - addr[1:0]≠0 → sberror=3.
- Completion:
  - bus_err → sberror=2.
  - Timeout → sberror=1.
  - bus_ack on READ → SBDATA0 ← bus_rdata.
- Autoincrement: on successful completion with sbautoincrement=1, SBADDRESS0 += 4, wrapping 0xFFFFFFFC→0. No increment on error.
- Reset values: bus_rd=bus_wr=0, bus_addr=bus_wdata=0, SBADDRESS0=SBDATA0=0, sbcs writable bits 0 except sbaccess=2, FSM=IDLE.

## Timing
- Register write at edge N → bus_rd/bus_wr high from N+1. sbbusy reads 1 from N+1.
- Strobe, address and data are held stable until the first edge where bus_ack or bus_err is sampled high (edge M).
- At edge M:
  - Strobe drops at M+1.
  - SBDATA0, SBADDRESS0 and sberror update at M+1.
  - sbbusy=0 at M+1; a new access may start on a register write in that same cycle.
- Minimum access: 2 cycles, ack in the first request cycle.
- Timeout: counter loads 0 at start. If no completion is seen within TimeoutCycles request cycles, the strobe drops on the next edge, with sberror=1.
- Pre-check failures: sberror is set at N+1, sbbusy never rises.
- Reset mid-access: strobes drop at the reset edge. The responder must tolerate an abandoned request.

## Configuration
- SBA_TIMEOUT_EN defined: timeout counter present, behaviour as above.
- SBA_TIMEOUT_EN undefined: no counter; the engine waits indefinitely for bus_ack/bus_err. TimeoutCycles is ignored and sberror=1 is never produced.

## Structure
- Package sba_pkg holds:
  - reg_sel constants: SbcsSel, SbAddrSel, SbDataSel;
  - sberror_e enum: NONE=0, TIMEOUT=1, BADADDR=2, ALIGN=3, SIZE=4;
  - FSM state typedef sba_state_e;
  - SBCS field bit-position constants.
- Single module, no sub-module. The timeout counter is an `ifdef`-guarded always block.

## Test plan
- Write SBADDRESS0=0x1000 (readonaddr=1), responder acks after 3 cycles with 0xDEADBEEF → bus_rd high 3 cycles, SBDATA0=0xDEADBEEF, sberror=0.
- autoincrement=1, SBADDRESS0=0x2000, write SBDATA0 0x11 then 0x22 → bus writes to 0x2000 and 0x2004, final SBADDRESS0=0x2008.
- Write SBADDRESS0=0x1002 (readonaddr=1) → no bus cycle, sberror=3; next SBDATA0 write is also blocked until W1C of sberror.
- Responder asserts bus_err on a write → sberror=2. Write SBDATA0 while a read is stalled → sbbusyerror=1 and bus_wdata unchanged.
- SBA_TIMEOUT_EN, TimeoutCycles=4, responder silent → strobe drops after 4 cycles, sberror=1. Without the macro, strobe stays high 100+ cycles.
- Assert rst_n=0 mid-read → bus_rd=0 next edge, SBCS reads sbaccess=2, sbbusy=0, SBDATA0=0.
